erm16_bus_responder: RTL and testbench
======================================

Name: erm16_bus_responder

Overview:
- Memory/I-O responder on the far side of the ERM16 core bus.
- Consumes the core's ADDR_BUS, DO, wrmem, ioe and intreq; returns read data to the core's DI.
- Contains a word-addressed program/data RAM with a host preload port, a small I/O register file (GPIO, compare timer, status) and an interrupt-pending latch for an external host.

Parameters:
- AW, 8, RAM address width; RAM depth is 2^AW words of 16 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- addr  in  16  core ADDR_BUS
- wdata  in  16  core DO (write data)
- wrmem  in  1  core write strobe; write occurs at the clock edge where it is high
- ioe  in  1  1 = I/O space, 0 = memory space
- intreq  in  1  core interrupt request level
- rdata  out  16  read data to core DI
- ld_en  in  1  host preload write enable
- ld_addr  in  AW  host preload address
- ld_data  in  16  host preload data
- gpio_in  in  16  asynchronous external inputs
- gpio_out  out  16  output port register
- int_pending  out  1  latched core interrupt request
- int_ack  in  1  host clears int_pending
- timer_irq  out  1  sticky timer compare flag

Behaviour:
- Reset (rst=1 at an edge):
  - rdata=0, gpio_out=0, TIMER_CNT=0, TIMER_CMP=16'hFFFF, TIMER_CTRL=0, timer_irq=0, int_pending=0, gpio sync flops=0, intreq_prev=0.
  - RAM contents are not reset.
  - All writes, including preload, are suppressed during the reset cycle.
- Read:
  - rdata registered every cycle from the current addr/ioe; no read enable.
  - Latency 1 cycle.
  - RAM is read-before-write: a same-address write in that cycle returns the old word.
- Memory space (ioe=0):
  - addr[15:AW]==0 selects RAM word addr[AW-1:0].
  - Any other address reads 16'h0000; writes to it are ignored.
- Preload:
  - ld_en=1 writes ld_data to ld_addr.
  - In that cycle any CPU RAM write is dropped; preload has priority. rdata still updates.
- I/O space (ioe=1): decode addr[3:0]; addr[15:4] is ignored.
  - 0x0 GPIO_OUT: RW.
  - 0x1 GPIO_IN: RO. gpio_in passes through 2 flops, so it is visible 2 cycles after a change, plus 1 cycle read latency.
  - 0x2 TIMER_CNT: RO.
  - 0x3 TIMER_CMP: RW. A new value is used from the next cycle.
  - 0x4 TIMER_CTRL: bit0 enable, bit1 auto-reload (both RW). bit2 is write-1 clear counter (reads 0). bit15 is write-1 clear timer_irq; reads return timer_irq.
  - 0x5 INT_STATUS: RO. bit0=int_pending, bit1=timer_irq, other bits 0.
  - Other offsets read 0; writes are ignored.
- Timer:
  - While enabled, CNT increments by 1 per cycle, wrapping 16'hFFFF to 0.
  - When CNT==CMP and enabled: timer_irq sets.
  - On that match, if auto-reload=1 the next CNT is 0; otherwise counting continues.
  - A clear-counter write forces CNT=0 next cycle and overrides the increment.
  - Match and W1C of timer_irq in the same cycle: set wins.
  - With enable=0, CNT holds and no match is evaluated.
- Interrupt latch:
  - A rising edge of intreq (intreq & ~intreq_prev) sets int_pending.
  - int_ack clears it.
  - Edge and ack in the same cycle: set wins.
  - intreq held high does not re-set after ack.
  - intreq high in the first cycle after reset counts as an edge.

Test Plan:
- Preload 0x1234 to address 5, then read addr=0x0005, ioe=0 -> rdata=0x1234 one cycle later. Read addr=0x0105 (AW=8) -> 0x0000.
- CPU write 0xBEEF to addr 7 while reading addr 7 -> same-cycle read returns old value; next read returns 0xBEEF. Simultaneous ld_en to addr 7 with 0x0001 -> RAM holds 0x0001.
- I/O write 0x00A5 to offset 0 -> gpio_out=0x00A5. Drive gpio_in=0x5A5A -> I/O read of offset 1 returns 0x5A5A within 3 cycles.
- CMP=3, CTRL=0x0003 -> CNT sequence 1,2,3,0,1. timer_irq sets on the first match and stays set. INT_STATUS reads 0x0002. Writing CTRL=0x8003 clears it until the next match.
- Pulse intreq 0->1 -> int_pending=1 next cycle. Hold intreq high and assert int_ack -> int_pending=0 and stays 0. Edge coincident with int_ack -> int_pending=1.
- Assert rst mid-timer-count with wrmem=1 -> RAM unchanged; all outputs and registers at their reset values; CMP reads 0xFFFF.

Source files
------------

// File: rtl/erm16_bus_responder.sv
// Far-side responder for the ERM16 core bus: word RAM with host preload,
// GPIO / compare-timer / status I/O registers and a host interrupt latch.
module erm16_bus_responder #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   addr,
  input  logic [15:0]   wdata,
  input  logic          wrmem,
  input  logic          ioe,
  input  logic          intreq,
  output logic [15:0]   rdata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data,
  input  logic [15:0]   gpio_in,
  output logic [15:0]   gpio_out,
  output logic          int_pending,
  input  logic          int_ack,
  output logic          timer_irq
);

  localparam int DATA_W = 16;

  logic [DATA_W-1:0] mem [2**AW];

  logic [DATA_W-1:0] gpio_sync_p0;
  logic [DATA_W-1:0] gpio_sync_p1;
  logic [DATA_W-1:0] timer_cnt;
  logic [DATA_W-1:0] timer_cmp;
  logic              timer_en;
  logic              timer_ar;
  logic              intreq_prev;

  logic              mem_sel;
  logic              mem_we;
  logic              io_we;
  logic [3:0]        io_off;
  logic              ctrl_wr;
  logic              timer_match;
  logic [DATA_W-1:0] cnt_nxt;
  logic [DATA_W-1:0] rd_nxt;

  assign mem_sel     = (addr[15:AW] == '0);
  assign io_off      = addr[3:0];
  assign io_we       = wrmem & ioe;
  assign mem_we      = wrmem & ~ioe & mem_sel & ~ld_en;
  assign ctrl_wr     = io_we && (io_off == 4'h4);
  assign timer_match = timer_en && (timer_cnt == timer_cmp);

  // Host preload owns the write port whenever it is active.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_en)
        mem[ld_addr] <= ld_data;
      else if (mem_we)
        mem[addr[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    cnt_nxt = timer_cnt;
    if (ctrl_wr && wdata[2])
      cnt_nxt = '0;
    else if (timer_en)
      cnt_nxt = (timer_match && timer_ar) ? '0 : timer_cnt + 16'd1;
  end

  always_comb begin
    rd_nxt = '0;
    if (ioe) begin
      case (io_off)
        4'h0:    rd_nxt = gpio_out;
        4'h1:    rd_nxt = gpio_sync_p1;
        4'h2:    rd_nxt = timer_cnt;
        4'h3:    rd_nxt = timer_cmp;
        4'h4:    rd_nxt = {timer_irq, 13'd0, timer_ar, timer_en};
        4'h5:    rd_nxt = {14'd0, timer_irq, int_pending};
        default: rd_nxt = '0;
      endcase
    end else if (mem_sel) begin
      rd_nxt = mem[addr[AW-1:0]];
    end
  end

  // gpio_in -> p0 -> p1 synchroniser; read data and register file update together
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata        <= '0;
      gpio_out     <= '0;
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
      timer_cnt    <= '0;
      timer_cmp    <= 16'hFFFF;
      timer_en     <= 1'b0;
      timer_ar     <= 1'b0;
      timer_irq    <= 1'b0;
      int_pending  <= 1'b0;
      intreq_prev  <= 1'b0;
    end else begin
      rdata        <= rd_nxt;
      gpio_sync_p0 <= gpio_in;
      gpio_sync_p1 <= gpio_sync_p0;
      timer_cnt    <= cnt_nxt;
      intreq_prev  <= intreq;
      if (io_we && io_off == 4'h0)
        gpio_out <= wdata;
      if (io_we && io_off == 4'h3)
        timer_cmp <= wdata;
      if (ctrl_wr) begin
        timer_en <= wdata[0];
        timer_ar <= wdata[1];
      end
      if (timer_match)
        timer_irq <= 1'b1;
      else if (ctrl_wr && wdata[15])
        timer_irq <= 1'b0;
      if (intreq && !intreq_prev)
        int_pending <= 1'b1;
      else if (int_ack)
        int_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_erm16_bus_responder.sv
// Scoreboard bench for erm16_bus_responder: a behavioural model predicts every
// cycle's outputs, a monitor compares them one cycle after each stimulus.
module tb_erm16_bus_responder;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, wrmem, ioe, intreq, ld_en, int_ack;
  logic [15:0]   addr, wdata, ld_data, gpio_in;
  logic [AW-1:0] ld_addr;
  logic [15:0]   rdata, gpio_out;
  logic          int_pending, timer_irq;

  always #5 clk = ~clk;

  erm16_bus_responder #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wrmem(wrmem), .ioe(ioe),
    .intreq(intreq), .rdata(rdata), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .int_pending(int_pending), .int_ack(int_ack), .timer_irq(timer_irq)
  );

  typedef struct {
    logic [15:0] rd;
    bit          chk_rd;
    logic [15:0] go;
    bit          irq;
    bit          pend;
    int          ph;
    int          cno;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   phase = 0;
  int   cyc_no = 0;

  // Reference model state
  logic [15:0] m_mem [256];
  bit          m_init [256];
  logic [15:0] m_gpio, m_cnt, m_cmp;
  bit          m_en, m_ar, m_irq, m_pend, m_prev;
  logic [15:0] m_hist [2];

  task automatic chk(input string what, input int ph, input int cno,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s phase %0d cycle %0d: got %h expected %h", what, ph, cno, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    bit   match, w_io;
    logic [3:0] off;
    off = addr[3:0];
    e.rd = 16'h0000; e.chk_rd = 1'b1; e.ph = phase; e.cno = cyc_no;
    if (!rst) begin
      if (!ioe) begin
        if (addr < 16'd256) begin
          e.rd = m_mem[addr[7:0]];
          e.chk_rd = m_init[addr[7:0]];
        end
      end else begin
        case (off)
          4'h0: e.rd = m_gpio;
          4'h1: e.rd = m_hist[1];
          4'h2: e.rd = m_cnt;
          4'h3: e.rd = m_cmp;
          4'h4: e.rd = (m_irq ? 16'h8000 : 16'h0) | (m_ar ? 16'h2 : 16'h0) | (m_en ? 16'h1 : 16'h0);
          4'h5: e.rd = (m_irq ? 16'h2 : 16'h0) | (m_pend ? 16'h1 : 16'h0);
          default: e.rd = 16'h0000;
        endcase
      end
    end
    if (rst) begin
      m_gpio = 0; m_cnt = 0; m_cmp = 16'hFFFF; m_en = 0; m_ar = 0;
      m_irq = 0; m_pend = 0; m_prev = 0; m_hist[0] = 0; m_hist[1] = 0;
    end else begin
      w_io  = wrmem && ioe;
      match = m_en && (m_cnt == m_cmp);
      if (ld_en) begin
        m_mem[ld_addr] = ld_data;
        m_init[ld_addr] = 1'b1;
      end else if (wrmem && !ioe && addr < 16'd256) begin
        m_mem[addr[7:0]] = wdata;
      end
      if (w_io && off == 4'h4 && wdata[2]) m_cnt = 0;
      else if (m_en) m_cnt = (match && m_ar) ? 16'h0 : m_cnt + 16'd1;
      if (match) m_irq = 1;
      else if (w_io && off == 4'h4 && wdata[15]) m_irq = 0;
      if (w_io && off == 4'h3) m_cmp = wdata;
      if (w_io && off == 4'h4) begin m_en = wdata[0]; m_ar = wdata[1]; end
      if (w_io && off == 4'h0) m_gpio = wdata;
      if (intreq && !m_prev) m_pend = 1;
      else if (int_ack) m_pend = 0;
      m_prev = intreq;
      m_hist[1] = m_hist[0];
      m_hist[0] = gpio_in;
    end
    e.go = m_gpio; e.irq = m_irq; e.pend = m_pend;
    sbq.push_back(e);
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit io, input bit we, input logic [15:0] a,
                     input logic [15:0] wd, input bit ack, input bit ld,
                     input logic [7:0] la, input logic [15:0] ldd);
    rst = r; ioe = io; wrmem = we; addr = a; wdata = wd; int_ack = ack;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    step();
  endtask

  task automatic rd_mem(input logic [15:0] a); cyc(0, 0, 0, a, 0, 0, 0, 0, 0); endtask
  task automatic rd_io(input logic [15:0] a);  cyc(0, 1, 0, a, 0, 0, 0, 0, 0); endtask
  task automatic wr_io(input logic [15:0] a, input logic [15:0] d); cyc(0, 1, 1, a, d, 0, 0, 0, 0); endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk_rd) chk("rdata", e.ph, e.cno, rdata, e.rd);
        chk("gpio_out", e.ph, e.cno, gpio_out, e.go);
        chk("timer_irq", e.ph, e.cno, {15'd0, timer_irq}, {15'd0, e.irq});
        chk("int_pending", e.ph, e.cno, {15'd0, int_pending}, {15'd0, e.pend});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv, a, wd;
    bit r, io, we, ld, ack;
    for (int i = 0; i < 256; i++) m_init[i] = 1'b0;
    m_hist[0] = 0; m_hist[1] = 0;
    rst = 1; ioe = 0; wrmem = 0; addr = 0; wdata = 0; intreq = 0; int_ack = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; gpio_in = 0;
    @(negedge clk);

    phase = 0;
    cyc(1, 0, 0, 16'h0005, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 16'h0003, 0, 0, 0, 0, 0);

    phase = 1;
    for (int i = 0; i < 256; i++) begin
      rv = 16'($urandom);
      cyc(0, 0, 0, 16'(i), 0, 0, 1, 8'(i), rv);
    end
    cyc(0, 0, 0, 16'h0000, 0, 0, 1, 8'h05, 16'h1234);
    rd_mem(16'h0005);
    rd_mem(16'h0105);
    cyc(0, 0, 1, 16'h0105, 16'hFFFF, 0, 0, 0, 0);
    rd_mem(16'h0005);

    phase = 2;
    cyc(0, 0, 1, 16'h0007, 16'hBEEF, 0, 0, 0, 0);
    rd_mem(16'h0007);
    cyc(0, 0, 1, 16'h0007, 16'h1111, 0, 1, 8'h07, 16'h0001);
    rd_mem(16'h0007);
    rd_mem(16'h0007);

    phase = 3;
    wr_io(16'h0000, 16'h00A5);
    gpio_in = 16'h5A5A;
    repeat (4) rd_io(16'hF001);
    rd_io(16'h1230);
    wr_io(16'h0007, 16'hFFFF);
    rd_io(16'h0007);

    phase = 4;
    wr_io(16'h0003, 16'h0003);
    wr_io(16'h0004, 16'h0003);
    repeat (8) rd_io(16'h0002);
    rd_io(16'h0005);
    rd_io(16'h0004);
    wr_io(16'h0004, 16'h8003);
    repeat (4) rd_io(16'h0005);
    wr_io(16'h0004, 16'h0007);
    repeat (2) rd_io(16'h0002);
    wr_io(16'h0004, 16'h0000);
    repeat (3) rd_io(16'h0002);
    wr_io(16'h0003, 16'h0005);
    wr_io(16'h0004, 16'h8005);
    repeat (10) rd_io(16'h0002);

    phase = 5;
    intreq = 1; rd_io(16'h0005);
    rd_io(16'h0005);
    cyc(0, 1, 0, 16'h0005, 0, 1, 0, 0, 0);
    repeat (3) rd_io(16'h0005);
    intreq = 0; rd_io(16'h0005);
    intreq = 1; cyc(0, 1, 0, 16'h0005, 0, 1, 0, 0, 0);
    rd_io(16'h0005);

    phase = 6;
    wr_io(16'h0003, 16'h0100);
    wr_io(16'h0004, 16'h0001);
    repeat (5) rd_io(16'h0002);
    cyc(1, 0, 1, 16'h0007, 16'hDEAD, 0, 1, 8'h07, 16'h7777);
    rd_mem(16'h0007);
    rd_io(16'h0003);
    rd_io(16'h0002);
    rd_io(16'h0004);
    rd_io(16'h0005);
    intreq = 0;

    phase = 7;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) intreq = ~intreq;
      if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
      r   = ($urandom_range(0, 99) == 0);
      io  = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 2) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      ack = ($urandom_range(0, 3) == 0);
      rv  = 16'($urandom);
      if (io) a = {rv[15:4], 4'($urandom_range(0, 7))};
      else    a = ($urandom_range(0, 7) == 0) ? rv : {8'h00, rv[7:0]};
      wd = 16'($urandom);
      if (io && a[3:0] == 4'h3 && $urandom_range(0, 1) == 1) wd = 16'($urandom_range(0, 40));
      if (io && a[3:0] == 4'h4 && $urandom_range(0, 1) == 1) wd = wd | 16'h0001;
      cyc(r, io, we, a, wd, ack, ld, 8'($urandom), 16'($urandom));
    end

    phase = 8;
    rd_mem(16'h0005);
    rd_io(16'h0005);
    @(posedge clk);
    #2;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
